// File: rtl/patcnt_pkg.sv
// ============================================================================
// Module      : patcnt_pkg
// Description : Shared types and constants for the bit-pattern count engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package patcnt_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LDPAT = 3'd1,
        SCAN  = 3'd2,
        WR0   = 3'd3,
        WR1   = 3'd4,
        WR2   = 3'd5,
        DONE  = 3'd6
    } state_t;

    localparam int PAT_ADDR_D = 32;
    localparam int RES_ADDR_D = 33;
    localparam int PAT_W      = 5;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/patcnt_match4.sv
// ============================================================================
// Module      : patcnt_match4
// Description : Compares the four 5-bit windows of an 8-bit source to a pattern.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module patcnt_match4
    import patcnt_pkg::*;
(
    input  logic [7:0]       src,
    input  logic [PAT_W-1:0] pat,
    output logic [3:0]       match
);

    for (genvar k = 0; k < 4; k++) begin : g_win
        assign match[k] = (src[k+4:k] == pat);
    end

endmodule

`default_nettype wire

// File: rtl/patcnt_engine.sv
// ============================================================================
// Module      : patcnt_engine
// Description : Reads a message and 5-bit pattern from memory, writes the
//               in-byte, any-in-byte and stream-wide match counts back.
//               Optional cycle counter output: define PATCNT_CYCLE_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module patcnt_engine
    import patcnt_pkg::*;
#(
    parameter int NUM_BYTES = 32,
    parameter int PAT_ADDR  = PAT_ADDR_D,
    parameter int RES_ADDR  = RES_ADDR_D,
    parameter int AW        = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rd_data,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wr_data
`ifdef PATCNT_CYCLE_CNT_EN
    ,
    output logic [15:0]   cycle_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_BYTES);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [PAT_W-1:0] pat;
    logic [3:0]       prev_lo;
    logic [7:0]       ctb;
    logic [7:0]       cto;
    logic [7:0]       cts;
    logic [AW-1:0]    addr_q;

    logic [7:0] cur;
    logic [7:0] cross_src;
    logic [3:0] m;
    logic [3:0] c;
    logic [2:0] pm;
    logic [2:0] pc;
    logic [7:0] ctb_nxt;
    logic [7:0] cto_nxt;
    logic [7:0] cts_nxt;
    logic       last;

    assign cur = mem_rd_data;
    // Crossing windows start in the previous byte's low nibble: x[11:4].
    assign cross_src = {prev_lo, cur[7:4]};

    patcnt_match4 u_match_in (
        .src   (cur),
        .pat   (pat),
        .match (m)
    );

    patcnt_match4 u_match_cross (
        .src   (cross_src),
        .pat   (pat),
        .match (c)
    );

    assign pm      = popcount4(m);
    assign pc      = popcount4(c);
    assign ctb_nxt = ctb + {5'b0, pm};
    assign cto_nxt = cto + {7'b0, |m};
    assign cts_nxt = cts + {5'b0, pm} + ((idx != '0) ? {5'b0, pc} : 8'd0);
    assign last    = (idx == IDX_W'(NUM_BYTES - 1));

    always_comb begin
        mem_addr = addr_q;
        case (state)
            LDPAT:   mem_addr = AW'(PAT_ADDR);
            SCAN:    mem_addr = AW'(idx);
            default: mem_addr = addr_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            done        <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_wr_data <= 8'd0;
            addr_q      <= '0;
            idx         <= '0;
            pat         <= '0;
            prev_lo     <= 4'd0;
            ctb         <= 8'd0;
            cto         <= 8'd0;
            cts         <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state <= LDPAT;
                end
                LDPAT: begin
                    pat     <= mem_rd_data[PAT_W-1:0];
                    ctb     <= 8'd0;
                    cto     <= 8'd0;
                    cts     <= 8'd0;
                    prev_lo <= 4'd0;
                    idx     <= '0;
                    state   <= SCAN;
                end
                SCAN: begin
                    ctb     <= ctb_nxt;
                    cto     <= cto_nxt;
                    cts     <= cts_nxt;
                    prev_lo <= cur[3:0];
                    idx     <= idx + 1'b1;
                    if (last) begin
                        state       <= WR0;
                        mem_wr_en   <= 1'b1;
                        addr_q      <= AW'(RES_ADDR);
                        mem_wr_data <= ctb_nxt;
                    end
                end
                WR0: begin
                    state       <= WR1;
                    addr_q      <= AW'(RES_ADDR + 1);
                    mem_wr_data <= cto;
                end
                WR1: begin
                    state       <= WR2;
                    addr_q      <= AW'(RES_ADDR + 2);
                    mem_wr_data <= cts;
                end
                WR2: begin
                    state       <= DONE;
                    mem_wr_en   <= 1'b0;
                    mem_wr_data <= 8'd0;
                    addr_q      <= '0;
                    done        <= 1'b1;
                end
                DONE: begin
                    if (start) begin
                        state <= LDPAT;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef PATCNT_CYCLE_CNT_EN
    // Zero while in LDPAT, then counts every busy cycle; holds in IDLE/DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= 16'd0;
        end else if (state == IDLE || state == DONE) begin
            if (start) cycle_cnt <= 16'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 16'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_patcnt_engine.sv
// ============================================================================
// Module      : tb_patcnt_engine
// Description : Directed, table-driven bench for patcnt_engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_patcnt_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        done;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_rd_data;
    logic        mem_wr_en;
    logic [7:0]  mem_wr_data;
`ifdef PATCNT_CYCLE_CNT_EN
    logic [15:0] cycle_cnt;
`endif

    logic [7:0] mem [0:255];
    logic [7:0] res [0:2];
    int         wr_total = 0;
    int         bad_wr = 0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    patcnt_engine dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .done        (done),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data)
`ifdef PATCNT_CYCLE_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt)
`endif
    );

    assign mem_rd_data = mem[mem_addr];

    // Result writes are captured separately so the read image stays bench-owned.
    always @(posedge clk) begin
        if (mem_wr_en) begin
            wr_total++;
            if (mem_addr >= 8'd33 && mem_addr <= 8'd35) res[mem_addr - 8'd33] = mem_wr_data;
            else bad_wr++;
        end
    end

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] rest;
        logic [7:0] patb;
        logic [7:0] e_ctb;
        logic [7:0] e_cto;
        logic [7:0] e_cts;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fill(input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] rest, input logic [7:0] patb);
        for (int i = 0; i < 32; i++) mem[i] = rest;
        mem[0]  = b0;
        mem[1]  = b1;
        mem[32] = patb;
    endtask

    // Latency counts the edge that samples start as edge 1.
    task automatic run_once(input bit hold, output int lat, output int strobes);
        int w0;
        @(negedge clk);
        start = 1'b1;
        w0    = wr_total;
        lat   = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
            if (!hold) start = 1'b0;
        end while (!done && lat < 100);
        strobes = wr_total - w0;
    endtask

    task automatic check_results(input string tag, input logic [7:0] e0,
                                 input logic [7:0] e1, input logic [7:0] e2);
        check({tag, "_ctb"}, res[0], e0);
        check({tag, "_cto"}, res[1], e1);
        check({tag, "_cts"}, res[2], e2);
    endtask

    initial begin
        int lat;
        int strobes;
        int w0;
        int n;

        vecs[0] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'd128, 8'd32, 8'd252};
        vecs[1] = '{8'h55, 8'h55, 8'h55, 8'hF5, 8'd64,  8'd32, 8'd126};
        vecs[2] = '{8'hAA, 8'hAA, 8'hAA, 8'h0A, 8'd64,  8'd32, 8'd126};
        vecs[3] = '{8'h07, 8'hC0, 8'h00, 8'h1F, 8'd0,   8'd0,  8'd1};
        vecs[4] = '{8'hFF, 8'hFF, 8'hFF, 8'h1F, 8'd128, 8'd32, 8'd252};
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        #12;
        check("rst_done", done, 1'b0);
        check("rst_wr_en", mem_wr_en, 1'b0);
        check("rst_addr", mem_addr, 8'd0);
        check("rst_wr_data", mem_wr_data, 8'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int v = 0; v < 5; v++) begin
            fill(vecs[v].b0, vecs[v].b1, vecs[v].rest, vecs[v].patb);
            run_once(1'b0, lat, strobes);
            check($sformatf("v%0d_latency", v), lat, 37);
            check($sformatf("v%0d_strobes", v), strobes, 3);
            check_results($sformatf("v%0d", v), vecs[v].e_ctb, vecs[v].e_cto, vecs[v].e_cts);
        end

        // Still in DONE after all-0xFF; rerun with pattern 0 must fully re-clear.
        mem[32] = 8'h00;
        run_once(1'b0, lat, strobes);
        check("rerun_latency", lat, 37);
        check("rerun_strobes", strobes, 3);
        check_results("rerun", 8'd0, 8'd0, 8'd0);

        // Abort by reset during SCAN at idx 10.
        fill(8'h55, 8'h55, 8'h55, 8'h15);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (mem_addr != 8'd10 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("abort_reach_idx10", mem_addr, 8'd10);
        w0 = wr_total;
        #2 reset = 1'b0;
        #1;
        check("abort_done", done, 1'b0);
        check("abort_wr_en", mem_wr_en, 1'b0);
        check("abort_addr", mem_addr, 8'd0);
        repeat (40) @(posedge clk);
        #1;
        check("abort_still_idle", done, 1'b0);
        check("abort_no_writes", wr_total - w0, 0);
        @(negedge clk);
        reset = 1'b1;
        run_once(1'b0, lat, strobes);
        check("post_abort_latency", lat, 37);
        check("post_abort_strobes", strobes, 3);
        check_results("post_abort", 8'd64, 8'd32, 8'd126);

        // Start held high: ignored while busy, re-triggers out of DONE.
        fill(8'h00, 8'h00, 8'h00, 8'h00);
        run_once(1'b1, lat, strobes);
        check("held_latency", lat, 37);
        check("held_strobes", strobes, 3);
        check_results("held", 8'd128, 8'd32, 8'd252);
`ifdef PATCNT_CYCLE_CNT_EN
        check("held_cycle_cnt", cycle_cnt, 16'd36);
`endif
        w0 = wr_total;
        n  = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
            if (n == 1) check("done_one_cycle", done, 1'b0);
        end while (!done && n < 100);
        start = 1'b0;
        check("retrigger_latency", n, 37);
        check("retrigger_strobes", wr_total - w0, 3);
        w0 = wr_total;
        repeat (3) @(posedge clk);
        #1;
        check("done_holds", done, 1'b1);
        check("done_no_strobe", wr_total - w0, 0);
        check("no_stray_writes", bad_wr, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
